// File: rtl/sram_req_arbiter.sv
// Two-master arbiter onto a single sram-like port: data beats inst in IDLE, a stalled
// grant is locked until accepted, and an owner FIFO steers in-order responses back.
module sram_req_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  // state  | meaning
  // IDLE   | no stalled grant; fixed priority data > inst
  // LOCK_I | inst request driven but not yet accepted; hold inst grant
  // LOCK_D | data request driven but not yet accepted; hold data grant

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [MAX_OUTST-1:0] owner_q;

  logic gate_open;
  logic grant_i;
  logic grant_d;
  logic push;
  logic pop;
  logic head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      LOCK_I:  grant_i = 1'b1;
      LOCK_D:  grant_d = 1'b1;
      default: begin
        grant_d = data_req;
        grant_i = inst_req && !data_req;
      end
    endcase
  end

  // Gate uses the registered count only, so a same-cycle response never opens a full window.
  assign gate_open = resetn && (cnt_q < CNT_W'(MAX_OUTST));
  assign mem_req   = gate_open && (grant_i || grant_d);
  assign mem_wr    = mem_req && grant_d && data_wr;
  assign mem_wstrb = mem_wr ? data_wstrb : '0;
  assign mem_addr  = !mem_req ? '0 : (grant_d ? data_addr : inst_addr);
  assign mem_wdata = (mem_req && grant_d) ? data_wdata : '0;

  assign push = mem_req && mem_addr_ok;
  assign pop  = resetn && mem_data_ok && (cnt_q != '0);
  assign head = owner_q[rd_ptr_q];

  assign inst_addr_ok = push && grant_i;
  assign data_addr_ok = push && grant_d;
  assign inst_data_ok = pop && !head;
  assign data_data_ok = pop && head;
  assign inst_rdata   = resetn ? mem_rdata : '0;
  assign data_rdata   = resetn ? mem_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      unique case (state_q)
        LOCK_I, LOCK_D: if (push) state_q <= IDLE;
        default:        if (mem_req && !mem_addr_ok) state_q <= grant_d ? LOCK_D : LOCK_I;
      endcase

      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase

      if (push) begin
        owner_q[wr_ptr_q] <= grant_d;
        wr_ptr_q          <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: accepted requests push their owner onto a
// scoreboard queue, and each memory response pops it to check data_ok routing.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic own_q[$];

  sram_req_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Call at the negedge of a cycle where an acceptance is expected.
  task automatic accept_chk(input string tag, input logic is_data);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'(1'b1));
    chk({tag, "_inst_aok"}, 64'(inst_addr_ok), 64'(!is_data));
    chk({tag, "_data_aok"}, 64'(data_addr_ok), 64'(is_data));
    own_q.push_back(is_data);
  endtask

  // Call at the negedge of a cycle with mem_data_ok=1 and mem_rdata=rd.
  task automatic rsp_chk(input string tag, input logic [31:0] rd);
    logic o;
    if (own_q.size() == 0) begin
      chk({tag, "_inst_dok"}, 64'(inst_data_ok), 64'(1'b0));
      chk({tag, "_data_dok"}, 64'(data_data_ok), 64'(1'b0));
    end else begin
      o = own_q.pop_front();
      chk({tag, "_inst_dok"}, 64'(inst_data_ok), 64'(!o));
      chk({tag, "_data_dok"}, 64'(data_data_ok), 64'(o));
      chk({tag, "_rdata"}, 64'(o ? data_rdata : inst_rdata), 64'(rd));
    end
  endtask

  task automatic respond(input string tag, input logic [31:0] rd);
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    @(negedge clk);
    rsp_chk(tag, rd);
    next_cycle();
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; data_wr = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  initial begin
    resetn = 0; inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0;
    data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_aok", 64'({inst_addr_ok, data_addr_ok}), 0);
    chk("rst_dok", 64'({inst_data_ok, data_data_ok}), 0);
    chk("rst_cnt", 64'(dut.cnt_q), 0);
    next_cycle();
    resetn = 1;
    next_cycle();

    // 1: single inst read
    inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
    @(negedge clk);
    chk("t1_addr", 64'(mem_addr), 64'h1C00_0000);
    accept_chk("t1", 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("t1_cnt", 64'(dut.cnt_q), 1);
    next_cycle();
    respond("t1_rsp", 32'h0280_0000);
    @(negedge clk);
    chk("t1_cnt_end", 64'(dut.cnt_q), 0);
    next_cycle();

    // 2: simultaneous requests, data wins then inst
    inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_wr = 0; data_addr = 32'h1C00_1000; mem_addr_ok = 1;
    @(negedge clk);
    chk("t2_addr_d", 64'(mem_addr), 64'h1C00_1000);
    chk("t2_wr", 64'(mem_wr), 0);
    accept_chk("t2_d", 1'b1);
    next_cycle();
    data_req = 0;
    @(negedge clk);
    chk("t2_addr_i", 64'(mem_addr), 64'h1C00_0004);
    accept_chk("t2_i", 1'b0);
    next_cycle();
    idle_inputs();
    respond("t2_rsp0", 32'hAAAA_0001);
    respond("t2_rsp1", 32'hAAAA_0002);

    // 3: stalled inst grant stays locked against a later data request
    inst_req = 1; inst_addr = 32'h1C00_0040; mem_addr_ok = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) begin data_req = 1; data_addr = 32'h1C00_2000; end
      @(negedge clk);
      chk($sformatf("t3_lock_addr%0d", c), 64'(mem_addr), 64'h1C00_0040);
      chk($sformatf("t3_lock_aok%0d", c), 64'({inst_addr_ok, data_addr_ok}), 0);
      next_cycle();
    end
    mem_addr_ok = 1;
    @(negedge clk);
    chk("t3_addr_i", 64'(mem_addr), 64'h1C00_0040);
    accept_chk("t3_i", 1'b0);
    next_cycle();
    inst_req = 0;
    @(negedge clk);
    chk("t3_addr_d", 64'(mem_addr), 64'h1C00_2000);
    accept_chk("t3_d", 1'b1);
    next_cycle();
    idle_inputs();
    respond("t3_rsp0", 32'hBBBB_0001);
    respond("t3_rsp1", 32'hBBBB_0002);

    // 4: outstanding limit, gate not opened by same-cycle response, push+pop
    inst_req = 1; inst_addr = 32'h1C00_0080; mem_addr_ok = 1;
    @(negedge clk);
    accept_chk("t4_i", 1'b0);
    next_cycle();
    inst_req = 0; data_req = 1; data_addr = 32'h1C00_3000;
    @(negedge clk);
    accept_chk("t4_d", 1'b1);
    next_cycle();
    data_req = 0; inst_req = 1; inst_addr = 32'h1C00_0084;
    @(negedge clk);
    chk("t4_full_req", 64'(mem_req), 0);
    chk("t4_full_aok", 64'({inst_addr_ok, data_addr_ok}), 0);
    chk("t4_cnt2", 64'(dut.cnt_q), 2);
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("t4_gate_same", 64'(mem_req), 0);
    rsp_chk("t4_rsp0", 32'h1111_1111);
    next_cycle();
    mem_rdata = 32'h2222_2222;
    @(negedge clk);
    chk("t4_cnt1", 64'(dut.cnt_q), 1);
    chk("t4_addr_pp", 64'(mem_addr), 64'h1C00_0084);
    rsp_chk("t4_rsp1", 32'h2222_2222);
    accept_chk("t4_pp", 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("t4_cnt_pp", 64'(dut.cnt_q), 1);
    next_cycle();
    respond("t4_rsp2", 32'h3333_3333);

    // 5: data write, then a stray response with empty FIFO
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_addr = 32'h1C00_0100;
    data_wdata = 32'hDEAD_BEEF; mem_addr_ok = 1;
    @(negedge clk);
    chk("t5_wr", 64'(mem_wr), 1);
    chk("t5_wstrb", 64'(mem_wstrb), 64'h3);
    chk("t5_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    accept_chk("t5_d", 1'b1);
    next_cycle();
    idle_inputs();
    respond("t5_rsp", 32'h0);
    respond("t5_stray", 32'h5555_5555);
    @(negedge clk);
    chk("t5_cnt", 64'(dut.cnt_q), 0);
    next_cycle();

    // 6: reset with two in flight
    inst_req = 1; inst_addr = 32'h1C00_0200; mem_addr_ok = 1;
    @(negedge clk);
    accept_chk("t6_i", 1'b0);
    next_cycle();
    inst_req = 0; data_req = 1; data_addr = 32'h1C00_4000;
    @(negedge clk);
    accept_chk("t6_d", 1'b1);
    next_cycle();
    inst_req = 1; data_req = 0; mem_data_ok = 1; mem_rdata = 32'h7777_7777;
    resetn = 0;
    #1;
    chk("t6_rst_req", 64'(mem_req), 0);
    chk("t6_rst_aok", 64'({inst_addr_ok, data_addr_ok}), 0);
    chk("t6_rst_dok", 64'({inst_data_ok, data_data_ok}), 0);
    chk("t6_rst_cnt", 64'(dut.cnt_q), 0);
    own_q.delete();
    next_cycle();
    idle_inputs();
    mem_rdata = '0;
    resetn = 1;
    next_cycle();
    inst_req = 1; inst_addr = 32'h1C00_0300; mem_addr_ok = 1;
    @(negedge clk);
    chk("t6_post_addr", 64'(mem_addr), 64'h1C00_0300);
    accept_chk("t6_post", 1'b0);
    next_cycle();
    idle_inputs();
    respond("t6_rsp", 32'h0BAD_F00D);
    chk("t6_q_empty", 64'(own_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
